// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared mode encodings and elaboration helpers for the CNN datapath blocks
package cnn_pkg;
  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction
endpackage

// File: rtl/pool_combine.sv
// rtl/pool_combine.sv - per-channel max or sum of two packed operands, selected by pooling mode
module pool_combine
  import cnn_pkg::*;
#(
  parameter int W  = 10,
  parameter int CH = 1
) (
  input  logic          mode,
  input  logic [CH*W-1:0] a,
  input  logic [CH*W-1:0] b,
  output logic [CH*W-1:0] y
);
  always_comb begin
    y = '0;
    for (int c = 0; c < CH; c++) begin
      if (mode == MODE_AVG)
        y[c*W +: W] = a[c*W +: W] + b[c*W +: W];
      else
        y[c*W +: W] = (a[c*W +: W] > b[c*W +: W]) ? a[c*W +: W] : b[c*W +: W];
    end
  end
endmodule

// File: rtl/pool2d_unit.sv
// rtl/pool2d_unit.sv - streaming 2D max/average pooling over raster-order pixels
module pool2d_unit
  import cnn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH     = 1,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic                 mode,
  output logic                 out_valid,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_last,
  output logic                 frame_err
);
  localparam int LOG2P = clog2(POOL);
  localparam int SHIFT = 2 * LOG2P;
  localparam int ACC_W = DATA_W + SHIFT;
  localparam int OW    = IMG_W / POOL;
  localparam int OH    = IMG_H / POOL;
  localparam int CW    = (clog2(IMG_W) > 0) ? clog2(IMG_W) : 1;
  localparam int RW    = (clog2(IMG_H) > 0) ? clog2(IMG_H) : 1;
  localparam int OXW   = (clog2(OW) > 0) ? clog2(OW) : 1;

  if (!(POOL == 2 || POOL == 4) || IMG_W < POOL || IMG_H < POOL) begin : g_param_err
    $error("pool2d_unit: POOL must be 2 or 4 and no larger than IMG_W and IMG_H");
  end

  logic [CW-1:0]       col, ecol;
  logic [RW-1:0]       row, erow;
  logic                mode_q, eff_mode;
  logic                at_origin, first_px, restart;
  logic                in_win, h_end, v_end, fire, last_win;
  logic [LOG2P-1:0]    px, py;
  logic [OXW-1:0]      ox;
  logic [CH*ACC_W-1:0] pix_ext, hpart, h_y, rb_rd, v_y;
  logic [CH*ACC_W-1:0] rowbuf [OW];
  logic [CH*DATA_W-1:0] result;

  // A mid-frame sof re-anchors the beat at (0,0); offset-0 overwrites then drop stale partials.
  always_comb begin
    at_origin = (col == '0) && (row == '0);
    first_px  = in_valid && (at_origin || in_sof);
    restart   = in_valid && in_sof && !at_origin;
    ecol      = restart ? '0 : col;
    erow      = restart ? '0 : row;
    eff_mode  = first_px ? mode : mode_q;
    px        = ecol[LOG2P-1:0];
    py        = erow[LOG2P-1:0];
    in_win    = (int'(ecol) < OW * POOL) && (int'(erow) < OH * POOL);
    ox        = in_win ? OXW'(ecol >> LOG2P) : '0;
    h_end     = int'(px) == POOL - 1;
    v_end     = int'(py) == POOL - 1;
    fire      = in_valid && in_win && h_end && v_end;
    last_win  = (int'(ecol >> LOG2P) == OW - 1) && (int'(erow >> LOG2P) == OH - 1);
    rb_rd     = rowbuf[ox];
    pix_ext   = '0;
    result    = '0;
    for (int c = 0; c < CH; c++) begin
      pix_ext[c*ACC_W +: ACC_W] = ACC_W'(in_data[c*DATA_W +: DATA_W]);
      if (eff_mode == MODE_AVG)
        result[c*DATA_W +: DATA_W] = DATA_W'(v_y[c*ACC_W +: ACC_W] >> SHIFT);
      else
        result[c*DATA_W +: DATA_W] = DATA_W'(v_y[c*ACC_W +: ACC_W]);
    end
  end

  pool_combine #(.W(ACC_W), .CH(CH)) u_hcomb (
    .mode (eff_mode),
    .a    (hpart),
    .b    (pix_ext),
    .y    (h_y)
  );

  pool_combine #(.W(ACC_W), .CH(CH)) u_vcomb (
    .mode (eff_mode),
    .a    (rb_rd),
    .b    (h_y),
    .y    (v_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      mode_q    <= MODE_MAX;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
      out_data  <= '0;
      hpart     <= '0;
      for (int i = 0; i < OW; i++) rowbuf[i] <= '0;
    end else begin
      out_valid <= fire;
      out_last  <= fire && last_win;
      frame_err <= restart;
      if (in_valid) begin
        mode_q <= eff_mode;
        if (int'(ecol) == IMG_W - 1) begin
          col <= '0;
          row <= (int'(erow) == IMG_H - 1) ? '0 : erow + RW'(1);
        end else begin
          col <= ecol + CW'(1);
          row <= erow;
        end
        if (in_win) begin
          hpart <= (px == '0) ? pix_ext : h_y;
          if (h_end) rowbuf[ox] <= (py == '0) ? h_y : v_y;
          if (fire) out_data <= result;
        end
      end
    end
  end
endmodule

// File: tb/tb_pool2d_unit.sv
// tb/tb_pool2d_unit.sv - self-checking bench for pool2d_unit across three parameter sets
module tb_pool2d_unit;
  typedef struct {
    logic [15:0] data;
    logic        last;
    int          stamp;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       a_valid, a_sof, a_mode, a_ov, a_ol, a_fe;
  logic [7:0] a_data, a_od;
  logic       b_valid, b_sof, b_mode, b_ov, b_ol, b_fe;
  logic [7:0] b_data, b_od;
  logic        c_valid, c_sof, c_mode, c_ov, c_ol, c_fe;
  logic [15:0] c_data, c_od;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fe0 = 0, fe1 = 0, fe2 = 0, fe_stamp0 = 0;
  out_t cap0[$], cap1[$], cap2[$], expq[$];
  int pix[28][28][2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool2d_unit #(.DATA_W(8), .CH(1), .IMG_W(4), .IMG_H(4), .POOL(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_sof(a_sof), .in_data(a_data), .mode(a_mode),
    .out_valid(a_ov), .out_data(a_od), .out_last(a_ol), .frame_err(a_fe)
  );
  pool2d_unit #(.DATA_W(8), .CH(1), .IMG_W(5), .IMG_H(5), .POOL(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_sof(b_sof), .in_data(b_data), .mode(b_mode),
    .out_valid(b_ov), .out_data(b_od), .out_last(b_ol), .frame_err(b_fe)
  );
  pool2d_unit #(.DATA_W(8), .CH(2), .IMG_W(28), .IMG_H(28), .POOL(2)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_sof(c_sof), .in_data(c_data), .mode(c_mode),
    .out_valid(c_ov), .out_data(c_od), .out_last(c_ol), .frame_err(c_fe)
  );

  always @(negedge clk) begin : mon
    out_t t;
    if (a_ov) begin t.data = {8'h00, a_od}; t.last = a_ol; t.stamp = cyc; cap0.push_back(t); end
    if (b_ov) begin t.data = {8'h00, b_od}; t.last = b_ol; t.stamp = cyc; cap1.push_back(t); end
    if (c_ov) begin t.data = c_od; t.last = c_ol; t.stamp = cyc; cap2.push_back(t); end
    if (a_fe) begin fe0++; fe_stamp0 = cyc; end
    if (b_fe) fe1++;
    if (c_fe) fe2++;
  end

  // Reference: a pooled value straight from the pixel array, per channel.
  function automatic logic [15:0] window_value(int oy, int ox, int p, int nch, bit m);
    logic [15:0] res;
    int mx, s, v;
    res = '0;
    for (int ch = 0; ch < nch; ch++) begin
      mx = 0;
      s = 0;
      for (int y = 0; y < p; y++)
        for (int x = 0; x < p; x++) begin
          v = pix[oy*p+y][ox*p+x][ch];
          s += v;
          if (v > mx) mx = v;
        end
      res[ch*8 +: 8] = 8'(m ? s / (p * p) : mx);
    end
    return res;
  endfunction

  task automatic set_beat(int d, bit v, bit s, logic [15:0] data, bit m);
    case (d)
      0: begin a_valid = v; a_sof = s; a_data = data[7:0]; a_mode = m; end
      1: begin b_valid = v; b_sof = s; b_data = data[7:0]; b_mode = m; end
      default: begin c_valid = v; c_sof = s; c_data = data; c_mode = m; end
    endcase
  endtask

  task automatic idle(int d, int n);
    repeat (n) begin
      @(negedge clk);
      set_beat(d, 1'b0, 1'b0, 16'h0, 1'b0);
    end
  endtask

  // pat: 0 = raster index, 1 = random, 2 = all 200 with (4,4) = 255
  task automatic run_frame(int d, int w, int h, int p, int nch, bit m, int pat, int gap_pct,
                           int npix, bit first_sof, bit wiggle);
    int r, c, ow, oh;
    logic [15:0] word;
    out_t e;
    ow = w / p;
    oh = h / p;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        for (int ch = 0; ch < 2; ch++)
          case (pat)
            0: pix[y][x][ch] = (ch == 0) ? y * w + x : 0;
            1: pix[y][x][ch] = int'($urandom_range(255));
            default: pix[y][x][ch] = (y == 4 && x == 4) ? 255 : 200;
          endcase
    for (int i = 0; i < npix; i++) begin
      r = i / w;
      c = i % w;
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        set_beat(d, 1'b0, 1'b0, 16'(int'($urandom)), 1'($urandom));
      end
      word = '0;
      for (int ch = 0; ch < nch; ch++) word[ch*8 +: 8] = 8'(pix[r][c][ch]);
      @(negedge clk);
      set_beat(d, 1'b1, (i == 0) && first_sof, word, (i == 0 || !wiggle) ? m : 1'($urandom));
      if (r % p == p - 1 && c % p == p - 1 && r < oh * p && c < ow * p) begin
        e.data  = window_value(r / p, c / p, p, nch, m);
        e.last  = (r / p == oh - 1) && (c / p == ow - 1);
        e.stamp = cyc + 1;
        expq.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    logic ov, ol, fe;
    logic [15:0] od;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      case (d)
        0: begin ov = a_ov; ol = a_ol; fe = a_fe; od = {8'h00, a_od}; end
        1: begin ov = b_ov; ol = b_ol; fe = b_fe; od = {8'h00, b_od}; end
        default: begin ov = c_ov; ol = c_ol; fe = c_fe; od = c_od; end
      endcase
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d: got %b want 0", d, ov); end
      checks++; if (ol !== 1'b0) begin errors++; $display("FAIL reset_out_last dut%0d: got %b want 0", d, ol); end
      checks++; if (fe !== 1'b0) begin errors++; $display("FAIL reset_frame_err dut%0d: got %b want 0", d, fe); end
      checks++; if (od !== 16'h0) begin errors++; $display("FAIL reset_out_data dut%0d: got %h want 0", d, od); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_max_4x4();
    out_t got[$];
    int tbl[4];
    tbl = '{5, 7, 13, 15};
    run_frame(0, 4, 4, 2, 1, 1'b0, 0, 0, 16, 1'b1, 1'b0);
    idle(0, 3);
    got = cap0; cap0.delete();
    checks++; if (got.size() != expq.size()) begin errors++; $display("FAIL max4x4_count: got %0d want %0d", got.size(), expq.size()); end
    foreach (expq[i]) if (i < got.size()) begin
      checks++;
      if (got[i].data !== expq[i].data || got[i].last !== expq[i].last || got[i].stamp != expq[i].stamp) begin
        errors++; $display("FAIL max4x4_out[%0d]: got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d", i, got[i].data, got[i].last, got[i].stamp, expq[i].data, expq[i].last, expq[i].stamp);
      end
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i].data !== 16'(tbl[i])) begin errors++; $display("FAIL max4x4_const[%0d]: got %0d want %0d", i, got[i].data, tbl[i]); end
    end
    checks++; if (a_od !== 8'(tbl[3])) begin errors++; $display("FAIL max4x4_hold: got %0d want %0d", a_od, tbl[3]); end
    expq.delete();
  endtask

  task automatic test_avg_4x4();
    out_t got[$];
    int tbl[4];
    tbl = '{2, 4, 10, 12};
    run_frame(0, 4, 4, 2, 1, 1'b1, 0, 0, 16, 1'b1, 1'b1);
    idle(0, 3);
    got = cap0; cap0.delete();
    checks++; if (got.size() != expq.size()) begin errors++; $display("FAIL avg4x4_count: got %0d want %0d", got.size(), expq.size()); end
    foreach (expq[i]) if (i < got.size()) begin
      checks++;
      if (got[i].data !== expq[i].data || got[i].last !== expq[i].last || got[i].stamp != expq[i].stamp) begin
        errors++; $display("FAIL avg4x4_out[%0d]: got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d", i, got[i].data, got[i].last, got[i].stamp, expq[i].data, expq[i].last, expq[i].stamp);
      end
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i].data !== 16'(tbl[i])) begin errors++; $display("FAIL avg4x4_const[%0d]: got %0d want %0d", i, got[i].data, tbl[i]); end
    end
    expq.delete();
  endtask

  task automatic test_back_to_back();
    out_t got[$];
    int fe_before;
    fe_before = fe0;
    run_frame(0, 4, 4, 2, 1, 1'b1, 1, 0, 16, 1'b1, 1'b1);
    run_frame(0, 4, 4, 2, 1, 1'b0, 1, 0, 16, 1'b1, 1'b1);
    idle(0, 3);
    got = cap0; cap0.delete();
    checks++; if (got.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got.size()); end
    foreach (expq[i]) if (i < got.size()) begin
      checks++;
      if (got[i].data !== expq[i].data || got[i].last !== expq[i].last || got[i].stamp != expq[i].stamp) begin
        errors++; $display("FAIL b2b_out[%0d]: got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d", i, got[i].data, got[i].last, got[i].stamp, expq[i].data, expq[i].last, expq[i].stamp);
      end
    end
    checks++; if (fe0 != fe_before) begin errors++; $display("FAIL b2b_frame_err: got %0d pulses want 0", fe0 - fe_before); end
    expq.delete();
  endtask

  task automatic test_pool4_5x5();
    out_t got[$];
    run_frame(1, 5, 5, 4, 1, 1'b1, 2, 0, 25, 1'b1, 1'b0);
    idle(1, 3);
    got = cap1; cap1.delete();
    checks++; if (got.size() != 1) begin errors++; $display("FAIL pool4_count: got %0d want 1", got.size()); end
    foreach (expq[i]) if (i < got.size()) begin
      checks++;
      if (got[i].data !== expq[i].data || got[i].last !== expq[i].last || got[i].stamp != expq[i].stamp) begin
        errors++; $display("FAIL pool4_out[%0d]: got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d", i, got[i].data, got[i].last, got[i].stamp, expq[i].data, expq[i].last, expq[i].stamp);
      end
    end
    if (got.size() > 0) begin
      checks++; if (got[0].data !== 16'd200) begin errors++; $display("FAIL pool4_const: got %0d want 200", got[0].data); end
    end
    expq.delete();
  endtask

  task automatic test_random_28x28();
    out_t got[$];
    run_frame(2, 28, 28, 2, 2, 1'b0, 1, 30, 784, 1'b1, 1'b1);
    run_frame(2, 28, 28, 2, 2, 1'b1, 1, 30, 784, 1'b1, 1'b1);
    idle(2, 3);
    got = cap2; cap2.delete();
    checks++; if (got.size() != 392) begin errors++; $display("FAIL rand28_count: got %0d want 392", got.size()); end
    foreach (expq[i]) if (i < got.size()) begin
      checks++;
      if (got[i].data !== expq[i].data || got[i].last !== expq[i].last || got[i].stamp != expq[i].stamp) begin
        errors++; $display("FAIL rand28_out[%0d]: got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d", i, got[i].data, got[i].last, got[i].stamp, expq[i].data, expq[i].last, expq[i].stamp);
      end
    end
    checks++; if (c_od !== expq[expq.size()-1].data) begin errors++; $display("FAIL rand28_hold: got %h want %h", c_od, expq[expq.size()-1].data); end
    checks++; if (fe2 != 0) begin errors++; $display("FAIL rand28_frame_err: got %0d pulses want 0", fe2); end
    expq.delete();
  endtask

  task automatic test_sof_err();
    out_t got[$];
    int fe_before, c0;
    fe_before = fe0;
    run_frame(0, 4, 4, 2, 1, 1'b0, 1, 0, 7, 1'b1, 1'b0);
    c0 = cyc;
    run_frame(0, 4, 4, 2, 1, 1'b1, 1, 0, 16, 1'b1, 1'b0);
    idle(0, 3);
    got = cap0; cap0.delete();
    checks++; if (fe0 - fe_before != 1) begin errors++; $display("FAIL soferr_pulses: got %0d want 1", fe0 - fe_before); end
    checks++; if (fe_stamp0 != c0 + 2) begin errors++; $display("FAIL soferr_timing: got cyc %0d want %0d", fe_stamp0, c0 + 2); end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL soferr_count: got %0d want 5", got.size()); end
    foreach (expq[i]) if (i < got.size()) begin
      checks++;
      if (got[i].data !== expq[i].data || got[i].last !== expq[i].last || got[i].stamp != expq[i].stamp) begin
        errors++; $display("FAIL soferr_out[%0d]: got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d", i, got[i].data, got[i].last, got[i].stamp, expq[i].data, expq[i].last, expq[i].stamp);
      end
    end
    expq.delete();
  endtask

  task automatic test_reset_mid();
    out_t got[$];
    run_frame(0, 4, 4, 2, 1, 1'b1, 1, 0, 6, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    set_beat(0, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (a_ov !== 1'b0 || a_od !== 8'h0 || a_ol !== 1'b0 || a_fe !== 1'b0) begin
        errors++; $display("FAIL rstmid_zero[%0d]: got valid=%b data=%h last=%b err=%b want all 0", k, a_ov, a_od, a_ol, a_fe);
      end
    end
    rst = 1'b0;
    run_frame(0, 4, 4, 2, 1, 1'b0, 1, 20, 16, 1'b0, 1'b1);
    idle(0, 3);
    got = cap0; cap0.delete();
    checks++; if (got.size() != 5) begin errors++; $display("FAIL rstmid_count: got %0d want 5", got.size()); end
    foreach (expq[i]) if (i < got.size()) begin
      checks++;
      if (got[i].data !== expq[i].data || got[i].last !== expq[i].last || got[i].stamp != expq[i].stamp) begin
        errors++; $display("FAIL rstmid_out[%0d]: got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d", i, got[i].data, got[i].last, got[i].stamp, expq[i].data, expq[i].last, expq[i].stamp);
      end
    end
    checks++; if ({8'h00, a_od} !== expq[expq.size()-1].data) begin errors++; $display("FAIL rstmid_hold: got %h want %h", a_od, expq[expq.size()-1].data); end
    expq.delete();
  endtask

  initial begin
    set_beat(0, 1'b0, 1'b0, 16'h0, 1'b0);
    set_beat(1, 1'b0, 1'b0, 16'h0, 1'b0);
    set_beat(2, 1'b0, 1'b0, 16'h0, 1'b0);
    test_reset();
    test_max_4x4();
    test_avg_4x4();
    test_back_to_back();
    test_pool4_5x5();
    test_random_28x28();
    test_sof_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
